// File: rtl/ixc_assign_pipe.sv
// ixc_assign_pipe: WIDTH-bit elastic buffer of DEPTH entries moving R to L with valid/ready on both sides.
// Optional per-entry parity with sticky par_err when IXC_ASSIGN_PIPE_PARITY_EN is defined.
module ixc_assign_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R,
    input  logic             r_valid,
    output logic             r_ready,
    output logic [WIDTH-1:0] L,
    output logic             l_valid,
    input  logic             l_ready,
`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    output logic             par_err,
`endif
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    // Handshake: a word moves on R when r_valid&r_ready at a rising edge and
    // on L when l_valid&l_ready at a rising edge; neither ready depends
    // combinationally on the opposite side's valid or ready.

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             r_ready_q;
    logic [WIDTH-1:0] l_q;
    logic             push;
    logic             pop;
    logic [EW-1:0]    wr_word;
    logic             head_load;
    logic [EW-1:0]    head_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push       = r_valid & r_ready_q;
    assign pop        = l_valid & l_ready;
    assign rd_ptr_inc = ptr_inc(rd_ptr);

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    assign wr_word = {^R, R};
`else
    assign wr_word = R;
`endif

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // The head register reloads whenever the word at the front changes:
    // straight from R when the buffer is (or is about to become) otherwise
    // empty, else from the entry behind the one being popped. It holds the
    // last popped word when the buffer drains.
    always_comb begin
        head_load = 1'b0;
        head_word = mem[rd_ptr_inc];
        if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
            head_load = 1'b1;
            head_word = wr_word;
        end else if (pop && (count_q > CW'(1))) begin
            head_load = 1'b1;
            head_word = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            r_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count_q   <= count_next;
            r_ready_q <= (count_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q <= '0;
        end else if (head_load) begin
            l_q <= head_word[WIDTH-1:0];
        end
    end

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    logic l_par_q;
    logic par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_par_q   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (head_load) begin
                l_par_q <= head_word[WIDTH];
            end
            if (pop && (l_par_q != ^l_q)) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign par_err = par_err_q;
`endif

    assign r_ready = r_ready_q;
    assign L       = l_q;
    assign l_valid = (count_q != '0);
    assign count   = count_q;

endmodule
